// File: rtl/mcpu_vram_arbiter.sv
// Single-port VRAM sequencer: buffers CPU writes, orders CPU reads behind them, and
// round-robins VRAM write slots between the CPU write FIFO and the fill/DMA engine.
module mcpu_vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         display_on,
  input  logic                         cpu_we,
  input  logic [12:0]                  cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic                         cpu_wready,
  input  logic                         cpu_re,
  output logic [7:0]                   cpu_rdata,
  output logic                         cpu_rvalid,
  input  logic                         fill_req,
  input  logic [12:0]                  fill_addr,
  input  logic [7:0]                   fill_data,
  output logic                         fill_gnt,
  output logic [12:0]                  vram_addr,
  output logic                         vram_we,
  output logic                         vram_re,
  output logic [7:0]                   vram_wdata,
  input  logic [7:0]                   vram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  logic [12:0]   fifo_addr_q [FIFO_DEPTH];
  logic [12:0]   fifo_addr_d [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  rd_state_t     rd_state_q, rd_state_d;
  logic [12:0]   rd_addr_q, rd_addr_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          last_fill_q, last_fill_d;

  logic [12:0]   vram_addr_q, vram_addr_d;
  logic [7:0]    vram_wdata_q, vram_wdata_d;
  logic          vram_we_q, vram_we_d;
  logic          vram_re_q, vram_re_d;

  logic          fifo_empty_s;
  logic          push_s;
  logic          wr_ok_s;
  logic          rd_go_s;
  logic          gnt_fifo_s;
  logic          gnt_fill_s;

  assign cpu_wready = (count_q != CNT_FULL);
  assign fifo_count = count_q;
  assign cpu_rvalid = (rd_state_q == RD_DONE);
  assign cpu_rdata  = cpu_rdata_q;
  assign fill_gnt   = gnt_fill_s;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_re    = vram_re_q;
  assign vram_wdata = vram_wdata_q;

  // Slot decision: a pending read wins once no CPU write is buffered or arriving.
  always_comb begin
    fifo_empty_s = (count_q == CNT_ZERO);
    push_s       = cpu_we && cpu_wready;
    wr_ok_s      = !BLANK_ONLY || !display_on;
    rd_go_s      = !reset && (rd_state_q == RD_WAIT) && fifo_empty_s && !push_s;
    gnt_fifo_s   = 1'b0;
    gnt_fill_s   = 1'b0;
    if (reset || rd_go_s || !wr_ok_s) begin
      gnt_fifo_s = 1'b0;
      gnt_fill_s = 1'b0;
    end else if (!fifo_empty_s && fill_req) begin
      gnt_fifo_s = last_fill_q;
      gnt_fill_s = !last_fill_q;
    end else begin
      gnt_fifo_s = !fifo_empty_s;
      gnt_fill_s = fifo_empty_s && fill_req;
    end
  end

  // Write FIFO storage, pointers and occupancy.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push_s) begin
      fifo_addr_d[wr_ptr_q] = cpu_addr;
      fifo_data_d[wr_ptr_q] = cpu_wdata;
      wr_ptr_d              = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (gnt_fifo_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, gnt_fifo_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Next bus operation; address and write data hold when the slot is idle.
  always_comb begin
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    vram_we_d    = 1'b0;
    vram_re_d    = 1'b0;
    last_fill_d  = last_fill_q;
    if (rd_go_s) begin
      vram_re_d   = 1'b1;
      vram_addr_d = rd_addr_q;
    end else if (gnt_fifo_s) begin
      vram_we_d    = 1'b1;
      vram_addr_d  = fifo_addr_q[rd_ptr_q];
      vram_wdata_d = fifo_data_q[rd_ptr_q];
      last_fill_d  = 1'b0;
    end else if (gnt_fill_s) begin
      vram_we_d    = 1'b1;
      vram_addr_d  = fill_addr;
      vram_wdata_d = fill_data;
      last_fill_d  = 1'b1;
    end else begin
      vram_addr_d = vram_addr_q;
    end
  end

  // Read sequencing; a read and write arriving together let the write enter the FIFO first.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_addr_d   = rd_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (cpu_re && !cpu_we) begin
          rd_state_d = RD_WAIT;
          rd_addr_d  = cpu_addr;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (rd_go_s) begin
          rd_state_d = RD_ISSUE;
        end else begin
          rd_state_d = RD_WAIT;
        end
      end
      RD_ISSUE: begin
        rd_state_d  = RD_DONE;
        cpu_rdata_d = vram_rdata;
      end
      RD_DONE: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // State registers; reset drops buffered writes and any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= 13'h0000;
        fifo_data_q[i] <= 8'h00;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= CNT_ZERO;
      rd_state_q   <= RD_IDLE;
      rd_addr_q    <= 13'h0000;
      cpu_rdata_q  <= 8'h00;
      last_fill_q  <= 1'b1;
      vram_addr_q  <= 13'h0000;
      vram_wdata_q <= 8'h00;
      vram_we_q    <= 1'b0;
      vram_re_q    <= 1'b0;
    end else begin
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_state_q   <= rd_state_d;
      rd_addr_q    <= rd_addr_d;
      cpu_rdata_q  <= cpu_rdata_d;
      last_fill_q  <= last_fill_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      vram_we_q    <= vram_we_d;
      vram_re_q    <= vram_re_d;
    end
  end

endmodule

// File: tb/tb_mcpu_vram_arbiter.sv
// Bench for mcpu_vram_arbiter: directed scenarios then random traffic, checked against a
// queue-based transaction model and a shadow copy of VRAM contents.
module tb_mcpu_vram_arbiter;
  localparam int DEPTH    = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_ISSUE = 2;
  localparam int PH_DONE  = 3;

  logic        clk = 1'b0;
  logic        reset, display_on, cpu_we, cpu_re, fill_req;
  logic [12:0] cpu_addr, fill_addr, vram_addr;
  logic [7:0]  cpu_wdata, fill_data, cpu_rdata, vram_wdata, vram_rdata;
  logic        cpu_wready, cpu_rvalid, fill_gnt, vram_we, vram_re;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  mcpu_vram_arbiter #(.FIFO_DEPTH(DEPTH), .BLANK_ONLY(1'b1)) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wready(cpu_wready),
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_data(fill_data), .fill_gnt(fill_gnt),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_re(vram_re), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .fifo_count(fifo_count)
  );

  // VRAM array driven by the DUT's bus
  logic [7:0] vmem [8192] = '{default: 8'h00};
  assign vram_rdata = vmem[vram_addr];
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_wdata;
  end

  // Reference model state
  logic [7:0]  exp_mem [8192] = '{default: 8'h00};
  logic [12:0] q_a[$];
  logic [7:0]  q_d[$];
  int          m_rd = PH_IDLE;
  logic [12:0] m_rd_addr = 13'h0;
  logic        m_last_fill = 1'b1;
  logic        m_gnt_fill = 1'b0;
  logic        e_we = 1'b0, e_re = 1'b0, e_rvalid = 1'b0;
  logic [12:0] e_addr = 13'h0;
  logic [7:0]  e_wdata = 8'h0, e_rdata = 8'h0;
  int          n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: inputs already driven just after the falling edge.
  task automatic tick();
    logic push, rd_go, g_fifo, g_fill;
    #1;
    check_val("cpu_wready", 32'(cpu_wready), 32'(q_a.size() < DEPTH));
    push   = cpu_we && (q_a.size() < DEPTH);
    rd_go  = !reset && (m_rd == PH_WAIT) && (q_a.size() == 0) && !push;
    g_fifo = 1'b0;
    g_fill = 1'b0;
    if (!reset && !rd_go && !display_on) begin
      if (q_a.size() > 0 && fill_req) begin
        if (m_last_fill) g_fifo = 1'b1;
        else g_fill = 1'b1;
      end else if (q_a.size() > 0) begin
        g_fifo = 1'b1;
      end else begin
        g_fill = fill_req;
      end
    end
    check_val("fill_gnt", 32'(fill_gnt), 32'(g_fill));
    m_gnt_fill = g_fill;
    if (reset) begin
      q_a.delete(); q_d.delete();
      m_rd = PH_IDLE; m_rd_addr = 13'h0; m_last_fill = 1'b1;
      e_we = 1'b0; e_re = 1'b0; e_rvalid = 1'b0;
      e_addr = 13'h0; e_wdata = 8'h0; e_rdata = 8'h0;
    end else begin
      e_rvalid = (m_rd == PH_ISSUE);
      if (m_rd == PH_ISSUE) e_rdata = exp_mem[m_rd_addr];
      e_we = 1'b0;
      e_re = 1'b0;
      if (rd_go) begin
        e_re = 1'b1; e_addr = m_rd_addr;
      end else if (g_fifo) begin
        e_we = 1'b1; e_addr = q_a.pop_front(); e_wdata = q_d.pop_front();
        exp_mem[e_addr] = e_wdata; m_last_fill = 1'b0;
      end else if (g_fill) begin
        e_we = 1'b1; e_addr = fill_addr; e_wdata = fill_data;
        exp_mem[e_addr] = e_wdata; m_last_fill = 1'b1;
      end
      case (m_rd)
        PH_IDLE:  if (cpu_re && !cpu_we) begin m_rd = PH_WAIT; m_rd_addr = cpu_addr; end
        PH_WAIT:  if (rd_go) m_rd = PH_ISSUE;
        PH_ISSUE: m_rd = PH_DONE;
        default:  m_rd = PH_IDLE;
      endcase
      if (push) begin q_a.push_back(cpu_addr); q_d.push_back(cpu_wdata); end
    end
    @(posedge clk);
    @(negedge clk);
    check_val("vram_we", 32'(vram_we), 32'(e_we));
    check_val("vram_re", 32'(vram_re), 32'(e_re));
    check_val("vram_addr", 32'(vram_addr), 32'(e_addr));
    if (e_we) check_val("vram_wdata", 32'(vram_wdata), 32'(e_wdata));
    check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rvalid));
    check_val("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    check_val("fifo_count", 32'(fifo_count), 32'(q_a.size()));
  endtask

  initial begin
    int  n;
    int  n_we;
    logic got_rv;
    logic done_prev;
    int  rd_wait_cyc;

    reset = 1'b1; display_on = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; fill_req = 1'b0;
    cpu_addr = 13'h0; cpu_wdata = 8'h0; fill_addr = 13'h0; fill_data = 8'h0;
    @(posedge clk);
    @(negedge clk);

    // Reset held for two cycles
    tick(); tick();
    check_val("rst_wready", 32'(cpu_wready), 32'h1);
    check_val("rst_count", 32'(fifo_count), 32'h0);
    check_val("rst_fill_gnt", 32'(fill_gnt), 32'h0);
    reset = 1'b0;

    // Write then read back the same address
    cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h5A;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1;
    tick();
    check_val("wr_we", 32'(vram_we), 32'h1);
    check_val("wr_addr", 32'(vram_addr), 32'h0123);
    check_val("wr_data", 32'(vram_wdata), 32'h5A);
    n = 1;
    while (!cpu_rvalid && n < 10) begin tick(); n++; end
    check_val("rd_latency", 32'(n), 32'h3);
    check_val("rd_data", 32'(cpu_rdata), 32'h5A);
    tick();
    cpu_re = 1'b0;

    // Writes held off during active display until the FIFO is full
    display_on = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 13'h0100 + 13'(i); cpu_wdata = 8'hA0 + 8'(i);
      tick();
    end
    cpu_we = 1'b0;
    check_val("full_count", 32'(fifo_count), 32'h4);
    check_val("full_wready", 32'(cpu_wready), 32'h0);
    display_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("drain_we", 32'(vram_we), 32'h1);
      check_val("drain_addr", 32'(vram_addr), 32'h0100 + 32'(i));
    end
    check_val("drain_wready", 32'(cpu_wready), 32'h1);

    // Round robin between three buffered writes and a continuous fill request
    reset = 1'b1; tick(); reset = 1'b0;
    display_on = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 13'h0300 + 13'(i); cpu_wdata = 8'h30 + 8'(i);
      tick();
    end
    cpu_we = 1'b0; display_on = 1'b0;
    fill_req = 1'b1; fill_addr = 13'h0400; fill_data = 8'hF0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("rr_gnt", 32'(m_gnt_fill), 32'(i % 2));
      check_val("rr_we", 32'(vram_we), 32'h1);
      if (m_gnt_fill) begin fill_addr = fill_addr + 13'h1; fill_data = fill_data + 8'h1; end
    end
    fill_req = 1'b0;
    tick();

    // A read never overtakes buffered CPU writes
    display_on = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0200; cpu_wdata = 8'hB0; tick();
    cpu_addr = 13'h0201; cpu_wdata = 8'hB1; tick();
    cpu_we = 1'b0; cpu_re = 1'b1; display_on = 1'b0;
    n_we = 0; got_rv = 1'b0;
    for (int i = 0; i < 12 && !got_rv; i++) begin
      tick();
      if (vram_we) n_we++;
      if (vram_re) check_val("ord_we_before_re", 32'(n_we), 32'h2);
      got_rv = cpu_rvalid;
    end
    check_val("ord_rvalid_seen", 32'(got_rv), 32'h1);
    check_val("ord_rdata", 32'(cpu_rdata), 32'hB1);
    tick();
    check_val("rvalid_width", 32'(cpu_rvalid), 32'h0);
    cpu_re = 1'b0;
    tick();

    // Reset while the read is on the bus
    cpu_re = 1'b1; cpu_addr = 13'h0123;
    for (int i = 0; i < 10 && !vram_re; i++) tick();
    check_val("mr_issue_seen", 32'(vram_re), 32'h1);
    reset = 1'b1; cpu_re = 1'b0;
    tick();
    check_val("mr_rvalid", 32'(cpu_rvalid), 32'h0);
    check_val("mr_vram_re", 32'(vram_re), 32'h0);
    check_val("mr_vram_addr", 32'(vram_addr), 32'h0);
    reset = 1'b0;
    tick();
    check_val("mr_rvalid_after", 32'(cpu_rvalid), 32'h0);

    // Random traffic
    done_prev = 1'b0; rd_wait_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 24) == 0) display_on = !display_on;
      if (!fill_req || m_gnt_fill) begin
        fill_req  = ($urandom_range(0, 2) == 0);
        fill_addr = 13'($urandom_range(0, 31));
        fill_data = 8'($urandom);
      end
      if (cpu_re) begin
        cpu_we = 1'b0;
        rd_wait_cyc++;
        if (reset || done_prev) begin
          cpu_re = 1'b0; rd_wait_cyc = 0;
        end else if (rd_wait_cyc > 300) begin
          check_val("rd_timeout", 32'(rd_wait_cyc), 32'h0);
          cpu_re = 1'b0; rd_wait_cyc = 0;
        end
      end else if (!reset && $urandom_range(0, 9) == 0) begin
        cpu_re = 1'b1; rd_wait_cyc = 0;
        cpu_addr = 13'($urandom_range(0, 31));
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_wdata = 8'($urandom);
      end else begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 13'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
      done_prev = e_rvalid;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcpu_vram_arbiter.md
# mcpu_vram_arbiter

Sequencing front-end for the 8 KB VRAM in `mcpu_gpu`, which has a single access port. It buffers CPU writes in a small FIFO and serves CPU reads with read-after-write ordering. It arbitrates round-robin between the CPU write FIFO and a fill/DMA requester. Optionally, it confines all VRAM writes to blanking intervals. It sits between the CPU bus decoder, the fill engine and the GPU's `vram_addr`/`vram_re`/`vram_we`/`data_bus` port.

## Interface
- FIFO_DEPTH, 4: CPU write FIFO entries; power of two, 2..16.
- BLANK_ONLY, 0: when 1, VRAM writes issue only while `display_on`=0.

- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- display_on  in  1  from video sync generator
- cpu_we  in  1  CPU write request; accepted when `cpu_wready`=1
- cpu_addr  in  13  CPU VRAM address (reads and writes)
- cpu_wdata  in  8  CPU write data
- cpu_wready  out  1  FIFO not full (combinational from count)
- cpu_re  in  1  CPU read request; held high until `cpu_rvalid`
- cpu_rdata  out  8  read data, valid with `cpu_rvalid`
- cpu_rvalid  out  1  one-cycle read completion pulse
- fill_req  in  1  fill engine write request; holds `fill_addr`/`fill_data` stable until granted
- fill_addr  in  13  fill write address
- fill_data  in  8  fill write data
- fill_gnt  out  1  one-cycle pulse: fill write accepted this cycle
- vram_addr  out  13  to GPU, registered
- vram_we  out  1  to GPU, registered
- vram_re  out  1  to GPU, registered
- vram_wdata  out  8  drive value for `data_bus` while `vram_we`=1, registered
- vram_rdata  in  8  `data_bus` sampled (valid while `vram_re`=1)
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **One VRAM operation per cycle.** The decision is made in cycle N and the bus outputs are registered for cycle N+1. With no operation, `vram_we`=`vram_re`=0 and the address holds its last value.
- **Write FIFO.**
  - Push when `cpu_we` and `cpu_wready`.
  - Pop when a FIFO write is granted.
  - A simultaneous push and pop on a full FIFO is not allowed, because `cpu_wready`=0 blocks the push. A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Write eligibility (`wr_ok`).** `wr_ok` = !BLANK_ONLY || !display_on, sampled in the decision cycle.
- **Priority per decision cycle.**
  1. Read issue, if the read FSM is in WAIT and FIFO is empty and no push occurs this cycle.
  2. Writes, when `wr_ok`. If only one of FIFO-nonempty / `fill_req` is present, grant it. If both, grant the source other than `last_wr`; `last_wr` updates on every write grant.
- **Read FSM.**
  - IDLE: `cpu_re` and not `cpu_we` -> WAIT. If `cpu_re` and `cpu_we` are both high, the write is pushed first and the FSM enters WAIT on the next cycle.
  - WAIT: wait until the FIFO is empty, then issue the read -> ISSUE. Reads are not gated by `wr_ok`. A read never bypasses a buffered CPU write; fill writes have no ordering guarantee versus CPU reads.
  - ISSUE: `vram_re`=1 on the bus. `cpu_rdata` <= `vram_rdata` at the end of the cycle -> DONE.
  - DONE: `cpu_rvalid`=1 for one cycle -> IDLE. The CPU drops `cpu_re` in the cycle after DONE. A new `cpu_re` is only sampled in IDLE.
- **Reset state.** All outputs 0, `cpu_wready`=1, FIFO empty, read FSM IDLE, `last_wr`=fill (so the FIFO wins the first tie). Reset mid-read discards the read with no `cpu_rvalid`. Reset mid-fill discards the buffered writes; an ungranted fill request stays pending.

## Timing
- CPU write: push at edge N; earliest grant cycle N+1; `vram_we` high in N+2; VRAM updated at end of N+2.
- CPU read with empty FIFO: `cpu_re` seen in cycle N (IDLE->WAIT); decision in N+1; `vram_re` in N+2; `cpu_rvalid` in N+3. Latency is 3 cycles plus the drain time of the FIFO.
- `fill_gnt` is asserted in the decision cycle. The fill engine may present the next request in the following cycle, giving 1 write/cycle when uncontended.
- With BLANK_ONLY=1 and `display_on`=1, no write is granted, `fill_gnt`=0, the FIFO fills, and `cpu_wready` falls at FIFO_DEPTH entries.
- Contended writes alternate FIFO/fill on every cycle.

## Test plan
- **Reset.** Assert reset 2 cycles -> all outputs 0, `cpu_wready`=1, `fifo_count`=0.
- **Write then read-back.** CPU writes 0x5A to 0x0123, then reads 0x0123 -> one `vram_we` with addr 0x0123 / wdata 0x5A precedes `vram_re`; `cpu_rdata`=0x5A with `cpu_rvalid` 3 cycles after the read FSM leaves IDLE.
- **Full FIFO.** BLANK_ONLY=1, `display_on`=1, 5 CPU writes -> 4 accepted, `cpu_wready`=0, `fifo_count`=4, no `vram_we`. Drop `display_on` -> 4 consecutive `vram_we` in order, `cpu_wready` back to 1.
- **Round robin.** FIFO holds 3 writes and `fill_req` is held continuously -> grants FIFO, fill, FIFO, fill, FIFO, fill; `fill_gnt` pulses every other cycle.
- **Read ordering.** Read requested while 2 writes are buffered -> `vram_re` only after both `vram_we` cycles; `cpu_rvalid` is exactly one cycle wide.
- **Reset mid-read.** Assert reset during ISSUE -> no `cpu_rvalid`, FSM IDLE, outputs 0 next cycle.
